fifo_frame_reader: RTL and testbench

//   Read-side drain for the switch port async FIFO, in the rclk domain. Pops bytes, delimits Ethernet frames

---
 rtl/eth_pkg.sv | 27 ++
 rtl/byte_skid_buf.sv | 50 +++++
 rtl/fifo_frame_reader.sv | 174 +++++++++++++++++
 tb/tb_fifo_frame_reader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
`default_nettype none
// eth_pkg: Ethernet constants, reader FSM states and frame length helper
// shared by the switch port datapath.
package eth_pkg;

  localparam int          ETH_HDR_LEN = 14;
  localparam int          ETH_FCS_LEN = 4;
  localparam logic [15:0] ETYPE_IPV4  = 16'h0800;
  localparam logic [15:0] ETYPE_MIN   = 16'h0600;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    BODY  = 2'd2,
    ERROR = 2'd3
  } reader_state_t;

  // Total on-wire length: header + payload padded to the floor + FCS.
  function automatic logic [10:0] frame_len_of(input logic [15:0] len,
                                               input logic [15:0] min_payload);
    logic [15:0] payload;
    payload = (len < min_payload) ? min_payload : len;
    return 11'(payload + 16'(ETH_HDR_LEN + ETH_FCS_LEN));
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_skid_buf.sv
`default_nettype none
// byte_skid_buf: 2-entry FIFO holding tagged bytes between the FIFO read
// port and the valid/ready output; the caller guarantees it is never pushed when full.
module byte_skid_buf #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic             pop;

  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_frame_reader.sv
`default_nettype none
// fifo_frame_reader: drains the async FIFO read side, delimits Ethernet frames
// from their length/EtherType fields and emits a valid/ready byte stream with SOF/EOF.
module fifo_frame_reader
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 5,
  parameter int MAX_PAYLOAD = 1500,
  parameter int MIN_PAYLOAD = 46
) (
  input  logic                  rclk,
  input  logic                  reset,
  input  logic                  empty,
  input  logic [ADDR_WIDTH:0]   fifo_occu_out,
  input  logic [DATA_WIDTH-1:0] read_data_out,
  output logic                  read_enable,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_sof,
  output logic                  tx_eof,
  output logic [15:0]           frame_count,
  output logic                  err_ethertype,
  output logic                  err_length
);

  reader_state_t state;
  logic          inflight;
  logic [10:0]   byte_idx;
  logic [10:0]   pend_idx;
  logic          pend_sof;
  logic          pend_eof;
  logic [10:0]   frame_len;
  logic [7:0]    type_hi;
  logic [7:0]    tl_hi;
  logic          is_ipv4;

  logic [1:0]    buf_count;
  logic [9:0]    buf_out;
  logic          beat;
  logic [2:0]    outstanding;
  logic          decode_now;
  logic [15:0]   type_word;
  logic [15:0]   tl_word;
  logic          type_len_bad;
  logic          type_unknown;
  logic          tl_bad;
  logic          go_error;
  logic          eof_read;
  logic          unused_occu;

  assign unused_occu = ^fifo_occu_out;

  assign type_word    = {type_hi, read_data_out};
  assign tl_word      = {tl_hi, read_data_out};
  assign decode_now   = inflight && (state == HDR);
  assign type_len_bad = (type_word < ETYPE_MIN) && (type_word > 16'(MAX_PAYLOAD));
  assign type_unknown = (type_word >= ETYPE_MIN) && (type_word != ETYPE_IPV4);
  assign tl_bad       = is_ipv4 && (tl_word > 16'(MAX_PAYLOAD));

  // A header byte that condemns the frame blocks the read in its own return cycle,
  // so nothing past the offending field is ever popped.
  assign go_error = decode_now &&
                    (((pend_idx == 11'd13) && (type_len_bad || type_unknown)) ||
                     ((pend_idx == 11'd17) && tl_bad));

  assign outstanding = {1'b0, buf_count} + {2'b00, inflight};
  assign read_enable = !reset && !empty && (state != ERROR) && !go_error &&
                       (outstanding < 3'd2);

  assign eof_read = (state == BODY) && (byte_idx == frame_len - 11'd1);

  byte_skid_buf #(
    .WIDTH (10)
  ) u_buf (
    .clk       (rclk),
    .rst       (reset),
    .push      (inflight),
    .push_data ({read_data_out, pend_sof, pend_eof}),
    .out_valid (tx_valid),
    .out_ready (tx_ready),
    .out_data  (buf_out),
    .count     (buf_count)
  );

  assign tx_data = buf_out[9:2];
  assign tx_sof  = buf_out[1];
  assign tx_eof  = buf_out[0];
  assign beat    = tx_valid && tx_ready;

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      inflight      <= 1'b0;
      byte_idx      <= '0;
      pend_idx      <= '0;
      pend_sof      <= 1'b0;
      pend_eof      <= 1'b0;
      frame_len     <= '0;
      type_hi       <= '0;
      tl_hi         <= '0;
      is_ipv4       <= 1'b0;
      frame_count   <= '0;
      err_ethertype <= 1'b0;
      err_length    <= 1'b0;
    end else begin
      inflight <= read_enable;

      if (beat && tx_eof) begin
        frame_count <= frame_count + 16'd1;
      end

      // Labels are assigned when the byte is requested, travelling with it to the buffer.
      if (read_enable) begin
        pend_idx <= byte_idx;
        pend_sof <= (state == IDLE);
        pend_eof <= eof_read;
        case (state)
          IDLE: begin
            byte_idx <= 11'd1;
            is_ipv4  <= 1'b0;
            state    <= HDR;
          end
          BODY: begin
            if (eof_read) begin
              byte_idx <= '0;
              state    <= IDLE;
            end else begin
              byte_idx <= byte_idx + 11'd1;
            end
          end
          default: byte_idx <= byte_idx + 11'd1;
        endcase
      end

      // Header fields are decoded as their bytes return, one cycle after the read.
      if (decode_now) begin
        case (pend_idx)
          11'd12: type_hi <= read_data_out;
          11'd13: begin
            if (type_unknown) begin
              err_ethertype <= 1'b1;
              state         <= ERROR;
            end else if (type_len_bad) begin
              err_length <= 1'b1;
              state      <= ERROR;
            end else if (type_word < ETYPE_MIN) begin
              frame_len <= frame_len_of(type_word, 16'(MIN_PAYLOAD));
              state     <= BODY;
            end else begin
              is_ipv4 <= 1'b1;
            end
          end
          11'd16: tl_hi <= read_data_out;
          11'd17: begin
            if (is_ipv4) begin
              if (tl_bad) begin
                err_length <= 1'b1;
                state      <= ERROR;
              end else begin
                frame_len <= frame_len_of(tl_word, 16'(MIN_PAYLOAD));
                state     <= BODY;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_frame_reader.sv
`default_nettype none
// tb_fifo_frame_reader: directed frames through a queue-modelled FIFO,
// checked beat-by-beat against hand-built expected streams.
module tb_fifo_frame_reader;

  logic        rclk = 1'b0;
  logic        reset;
  logic        empty;
  logic [5:0]  fifo_occu_out;
  logic [7:0]  read_data_out;
  logic        read_enable;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_sof;
  logic        tx_eof;
  logic [15:0] frame_count;
  logic        err_ethertype;
  logic        err_length;

  fifo_frame_reader dut (
    .rclk          (rclk),
    .reset         (reset),
    .empty         (empty),
    .fifo_occu_out (fifo_occu_out),
    .read_data_out (read_data_out),
    .read_enable   (read_enable),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_sof        (tx_sof),
    .tx_eof        (tx_eof),
    .frame_count   (frame_count),
    .err_ethertype (err_ethertype),
    .err_length    (err_length)
  );

  always #5 rclk = ~rclk;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] fifo_q[$];
  logic [9:0] exp_q[$];
  int         outstanding = 0;
  int         beats = 0;
  int         popped = 0;
  int         stall_at = -1;
  int         stall_cnt = 0;
  bit         toggle_ready = 0;
  bit         held_valid = 0;
  logic [9:0] held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_frame(input logic [15:0] etype, input logic [15:0] tl,
                           input int len, input int n_exp, input bit eof_exp);
    logic [47:0] dst;
    logic [31:0] fcs;
    logic [7:0]  b;
    dst = 48'h0010A47BEA80;
    fcs = 32'hE6C53DB2;
    for (int i = 0; i < len; i++) begin
      if (i < 6)                          b = dst[47-8*i -: 8];
      else if (i < 12)                    b = 8'h10 + 8'(i);
      else if (i == 12)                   b = etype[15:8];
      else if (i == 13)                   b = etype[7:0];
      else if (i >= len - 4)              b = fcs[31-8*(i-(len-4)) -: 8];
      else if (etype == 16'h0800 && i == 14) b = 8'h45;
      else if (etype == 16'h0800 && i == 16) b = tl[15:8];
      else if (etype == 16'h0800 && i == 17) b = tl[7:0];
      else                                b = 8'(i * 7 + 3);
      fifo_q.push_back(b);
      if (i < n_exp) exp_q.push_back({b, 1'(i == 0), 1'(eof_exp && i == len - 1)});
    end
    empty = (fifo_q.size() == 0);
    fifo_occu_out = 6'(fifo_q.size());
  endtask

  task automatic cyc();
    logic [9:0] obs;
    logic [9:0] exp;
    bit         acc;
    bit         rd;
    @(negedge rclk);
    obs = {tx_data, tx_sof, tx_eof};
    if (read_enable) chk("credit", 32'(outstanding < 2), 32'd1);
    if (empty) chk("re_while_empty", 32'(read_enable), 32'd0);
    if (held_valid) chk("hold", 32'({tx_valid, obs}), 32'({1'b1, held}));
    acc = tx_valid && tx_ready;
    if (acc) begin
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
      chk("beat", 32'(obs), 32'(exp));
      beats++;
    end
    held_valid = tx_valid && !tx_ready;
    held = obs;
    rd = read_enable;
    outstanding = outstanding + int'(rd) - int'(acc);
    @(posedge rclk);
    #1;
    if (rd) begin
      read_data_out = fifo_q.pop_front();
      popped++;
    end
    if (stall_cnt > 0) stall_cnt--;
    if (popped == stall_at) begin
      stall_cnt = 5;
      stall_at = -1;
    end
    empty = (fifo_q.size() == 0) || (stall_cnt > 0);
    fifo_occu_out = 6'(fifo_q.size());
    tx_ready = toggle_ready ? ~tx_ready : 1'b1;
  endtask

  task automatic run(input int maxc);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || tx_valid) && n < maxc) begin
      cyc();
      n++;
    end
    chk("run_bound", 32'(n < maxc), 32'd1);
    for (int i = 0; i < 4; i++) cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    fifo_q.delete();
    exp_q.delete();
    outstanding = 0;
    held_valid = 0;
    read_data_out = 8'h00;
    empty = 1'b1;
    fifo_occu_out = '0;
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    reset = 1'b0;
    @(posedge rclk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    empty = 1'b1;
    fifo_occu_out = '0;
    read_data_out = 8'h00;
    tx_ready = 1'b1;
    #1;
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_re", 32'(read_enable), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    chk("rst_errs", 32'({err_ethertype, err_length}), 32'd0);
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    reset = 1'b0;
    @(posedge rclk);
    #1;

    // 1: minimum IPv4 frame, free-running sink
    beats = 0;
    add_frame(16'h0800, 16'h002E, 64, 64, 1);
    run(400);
    chk("t1_beats", 32'(beats), 32'd64);
    chk("t1_count", 32'(frame_count), 32'd1);

    // 2: same frame with sink toggling ready every cycle
    beats = 0;
    toggle_ready = 1;
    add_frame(16'h0800, 16'h002E, 64, 64, 1);
    run(600);
    toggle_ready = 0;
    tx_ready = 1'b1;
    chk("t2_beats", 32'(beats), 32'd64);
    chk("t2_count", 32'(frame_count), 32'd2);

    // 3: padded 802.3 frame followed back-to-back by a 118-byte IPv4 frame
    beats = 0;
    add_frame(16'h0010, 16'h0000, 64, 64, 1);
    add_frame(16'h0800, 16'h0064, 118, 118, 1);
    run(800);
    chk("t3_beats", 32'(beats), 32'd182);
    chk("t3_count", 32'(frame_count), 32'd4);

    // 4a: unsupported EtherType: header bytes drain, then the reader parks
    beats = 0;
    add_frame(16'h86DD, 16'h0000, 64, 14, 0);
    run(200);
    chk("t4a_beats", 32'(beats), 32'd14);
    chk("t4a_err_type", 32'(err_ethertype), 32'd1);
    chk("t4a_err_len", 32'(err_length), 32'd0);
    chk("t4a_re", 32'(read_enable), 32'd0);
    chk("t4a_count", 32'(frame_count), 32'd4);
    do_reset();
    chk("t4a_rst_err", 32'(err_ethertype), 32'd0);

    // 4b: IPv4 total length 1501
    beats = 0;
    add_frame(16'h0800, 16'h05DD, 64, 18, 0);
    run(200);
    chk("t4b_beats", 32'(beats), 32'd18);
    chk("t4b_err_len", 32'(err_length), 32'd1);
    chk("t4b_err_type", 32'(err_ethertype), 32'd0);
    chk("t4b_re", 32'(read_enable), 32'd0);
    do_reset();

    // 5: FIFO runs dry for 5 cycles after 30 bytes have been popped
    beats = 0;
    popped = 0;
    stall_at = 30;
    add_frame(16'h0800, 16'h002E, 64, 64, 1);
    run(400);
    chk("t5_beats", 32'(beats), 32'd64);
    chk("t5_count", 32'(frame_count), 32'd1);

    // 6: reset mid-frame after 40 beats, then a fresh frame
    beats = 0;
    add_frame(16'h0800, 16'h002E, 64, 64, 1);
    for (int n = 0; n < 200 && beats < 40; n++) cyc();
    chk("t6_reach40", 32'(beats), 32'd40);
    reset = 1'b1;
    #1;
    chk("t6_rst_outs", 32'({tx_valid, tx_sof, tx_eof, tx_data, read_enable}), 32'd0);
    chk("t6_rst_count", 32'(frame_count), 32'd0);
    do_reset();
    beats = 0;
    add_frame(16'h0800, 16'h002E, 64, 64, 1);
    run(400);
    chk("t6_beats", 32'(beats), 32'd64);
    chk("t6_count", 32'(frame_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
